local_predictor_sequencer: RTL and testbench

Sequences all accesses to the single-ported local history table (LHT) and local prediction table (LPT) of the local branch predictor.
- Arbitrates between prediction lookups from fetch and resolved-branch updates from retire.
- Buffers pending updates in a small FIFO.
- Pipelines the dependent LHT-then-LPT read chain.
- Clears both tables with a post-reset sweep, replacing any per-entry reset in the tables themselves.

---
 rtl/lp_pkg.sv | 25 ++
 rtl/lp_update_fifo.sv | 43 ++++
 rtl/local_predictor_sequencer.sv | 153 +++++++++++++++
 tb/tb_local_predictor_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// rtl/lp_pkg.sv - shared types and constants for the local predictor sequencer
package lp_pkg;
    localparam int LP_PC_W     = 10;
    localparam int LP_HIST_W   = 10;
    localparam int LP_CNT_W    = 3;
    localparam int LP_UQ_DEPTH = 4;

    typedef enum logic {ST_INIT, ST_RUN} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_LOOKUP, OP_UPDATE} op_e;

    typedef struct packed {
        logic [LP_PC_W-1:0]   pc;
        logic [LP_HIST_W-1:0] hist;
        logic                 taken;
    } upd_entry_t;

    function automatic logic [LP_CNT_W-1:0] sat_update(input logic [LP_CNT_W-1:0] cnt,
                                                       input logic taken);
        if (taken && cnt != '1)
            return cnt + 1'b1;
        if (!taken && cnt != '0)
            return cnt - 1'b1;
        return cnt;
    endfunction
endpackage

// File: rtl/lp_update_fifo.sv
// rtl/lp_update_fifo.sv - small FIFO holding resolved-branch updates until they can issue
module lp_update_fifo
    import lp_pkg::*;
#(
    parameter int DEPTH = LP_UQ_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  upd_entry_t push_data,
    input  logic       pop,
    output upd_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    upd_entry_t     mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/local_predictor_sequencer.sv
// rtl/local_predictor_sequencer.sv - arbitrates and pipelines LHT/LPT accesses for the local predictor
module local_predictor_sequencer
    import lp_pkg::*;
#(
    parameter int PC_W     = LP_PC_W,
    parameter int HIST_W   = LP_HIST_W,
    parameter int CNT_W    = LP_CNT_W,
    parameter int UQ_DEPTH = LP_UQ_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              lookup_ready,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [HIST_W-1:0] upd_hist,
    input  logic              upd_taken,
    output logic              upd_ready,
    output logic              lht_en,
    output logic              lht_we,
    output logic [PC_W-1:0]   lht_addr,
    output logic [HIST_W-1:0] lht_wdata,
    input  logic [HIST_W-1:0] lht_rdata,
    output logic              lpt_en,
    output logic              lpt_we,
    output logic [HIST_W-1:0] lpt_addr,
    output logic [CNT_W-1:0]  lpt_wdata,
    input  logic [CNT_W-1:0]  lpt_rdata,
    output logic              init_busy
);
    localparam int SW = (PC_W > HIST_W) ? PC_W : HIST_W;
    localparam logic [SW-1:0] SWEEP_LAST = '1;

    state_e            state, state_next;
    logic [SW-1:0]     sweep_cnt;
    logic              bubble;
    op_e               s1_op, s2_op;
    logic [HIST_W-1:0] s1_hist, s2_hist;
    logic              s1_taken, s2_taken;
    upd_entry_t        uq_head, uq_in;
    logic              uq_full, uq_empty, uq_push, uq_pop;
    logic              run, lookup_fire;

    assign run          = (state == ST_RUN);
    assign init_busy    = !run;
    assign lookup_ready = run && !bubble && !uq_full;
    assign upd_ready    = run && !uq_full;
    assign lookup_fire  = lookup_valid && lookup_ready;
    assign uq_push      = upd_valid && upd_ready;
    assign uq_pop       = run && !lookup_fire && !bubble && !uq_empty;
    assign uq_in        = '{pc: upd_pc, hist: upd_hist, taken: upd_taken};

    lp_update_fifo #(.DEPTH(UQ_DEPTH)) u_uq (
        .clock     (clock),
        .reset     (reset),
        .push      (uq_push),
        .push_data (uq_in),
        .pop       (uq_pop),
        .head      (uq_head),
        .full      (uq_full),
        .empty     (uq_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_INIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == ST_INIT && sweep_cnt == SWEEP_LAST)
            state_next = ST_RUN;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_cnt  <= '0;
            bubble     <= 1'b0;
            s1_op      <= OP_NONE;
            s2_op      <= OP_NONE;
            s1_hist    <= '0;
            s2_hist    <= '0;
            s1_taken   <= 1'b0;
            s2_taken   <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_hist  <= '0;
        end else begin
            if (!run)
                sweep_cnt <= sweep_cnt + 1'b1;
            // The bubble keeps the update's s2 LPT write off the next op's s1 LPT read.
            bubble   <= uq_pop;
            s1_op    <= lookup_fire ? OP_LOOKUP : (uq_pop ? OP_UPDATE : OP_NONE);
            s1_hist  <= uq_head.hist;
            s1_taken <= uq_head.taken;
            s2_op    <= s1_op;
            s2_hist  <= (s1_op == OP_LOOKUP) ? lht_rdata : s1_hist;
            s2_taken <= s1_taken;
            pred_valid <= (s2_op == OP_LOOKUP);
            if (s2_op == OP_LOOKUP) begin
                pred_taken <= lpt_rdata[CNT_W-1];
                pred_hist  <= s2_hist;
            end
        end
    end

    always_comb begin
        lht_en    = 1'b0;
        lht_we    = 1'b0;
        lht_addr  = '0;
        lht_wdata = '0;
        lpt_en    = 1'b0;
        lpt_we    = 1'b0;
        lpt_addr  = '0;
        lpt_wdata = '0;
        if (!run) begin
            lht_en   = (sweep_cnt >> PC_W) == '0;
            lht_we   = lht_en;
            lht_addr = sweep_cnt[PC_W-1:0];
            lpt_en   = (sweep_cnt >> HIST_W) == '0;
            lpt_we   = lpt_en;
            lpt_addr = sweep_cnt[HIST_W-1:0];
        end else begin
            if (lookup_fire) begin
                lht_en   = 1'b1;
                lht_addr = lookup_pc;
            end else if (uq_pop) begin
                lht_en    = 1'b1;
                lht_we    = 1'b1;
                lht_addr  = uq_head.pc;
                lht_wdata = {uq_head.hist[HIST_W-2:0], uq_head.taken};
            end
            if (s2_op == OP_UPDATE) begin
                lpt_en    = 1'b1;
                lpt_we    = 1'b1;
                lpt_addr  = s2_hist;
                lpt_wdata = sat_update(lpt_rdata, s2_taken);
            end else if (s1_op == OP_LOOKUP) begin
                lpt_en   = 1'b1;
                lpt_addr = lht_rdata;
            end else if (s1_op == OP_UPDATE) begin
                lpt_en   = 1'b1;
                lpt_addr = s1_hist;
            end
        end
    end
endmodule

// File: tb/tb_local_predictor_sequencer.sv
// tb/tb_local_predictor_sequencer.sv - randomized self-checking bench for local_predictor_sequencer
module tb_local_predictor_sequencer;
    localparam int PC_W   = 10;
    localparam int HIST_W = 10;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 1024;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              lookup_valid = 1'b0;
    logic [PC_W-1:0]   lookup_pc = '0;
    logic              lookup_ready;
    logic              pred_valid, pred_taken;
    logic [HIST_W-1:0] pred_hist;
    logic              upd_valid = 1'b0;
    logic [PC_W-1:0]   upd_pc = '0;
    logic [HIST_W-1:0] upd_hist = '0;
    logic              upd_taken = 1'b0;
    logic              upd_ready;
    logic              lht_en, lht_we, lpt_en, lpt_we;
    logic [PC_W-1:0]   lht_addr;
    logic [HIST_W-1:0] lht_wdata, lht_rdata, lpt_addr;
    logic [CNT_W-1:0]  lpt_wdata, lpt_rdata;
    logic              init_busy;

    always #5 clock = ~clock;

    local_predictor_sequencer dut (
        .clock(clock), .reset(reset),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_hist(pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .upd_ready(upd_ready),
        .lht_en(lht_en), .lht_we(lht_we), .lht_addr(lht_addr), .lht_wdata(lht_wdata),
        .lht_rdata(lht_rdata),
        .lpt_en(lpt_en), .lpt_we(lpt_we), .lpt_addr(lpt_addr), .lpt_wdata(lpt_wdata),
        .lpt_rdata(lpt_rdata),
        .init_busy(init_busy)
    );

    // Single-ported tables with one-cycle read latency, no reset of their own.
    logic [HIST_W-1:0] lht_mem [DEPTH];
    logic [CNT_W-1:0]  lpt_mem [DEPTH];
    always @(posedge clock) begin
        if (lht_en) begin
            if (lht_we) lht_mem[lht_addr] <= lht_wdata;
            else        lht_rdata <= lht_mem[lht_addr];
        end
        if (lpt_en) begin
            if (lpt_we) lpt_mem[lpt_addr] <= lpt_wdata;
            else        lpt_rdata <= lpt_mem[lpt_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: tables change atomically when an op issues.
    typedef struct {int pc; int hist; int taken;} mupd_t;
    mupd_t mq[$];
    int    mlht [DEPTH];
    int    mlpt [DEPTH];
    bit    mbub;
    bit    sr0_v, sr1_v, po_v;
    int    sr0_t, sr0_h, sr1_t, sr1_h, po_t, po_h;
    bit    acc_upd;

    int lv, lpc, uv, upc, uhist, utaken;

    task automatic model_reset();
        mq.delete();
        mbub = 0;
        sr0_v = 0; sr1_v = 0; po_v = 0;
        sr0_t = 0; sr0_h = 0; sr1_t = 0; sr1_h = 0; po_t = 0; po_h = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mlht[i] = 0;
            mlpt[i] = 0;
        end
    endtask

    // Entered at a falling edge; drives one cycle, checks it, advances the model and clock.
    task automatic tick();
        bit exp_lr, exp_ur, fire, issue, nv;
        int nt, nh, c;
        mupd_t h, e;
        lookup_valid = lv[0]; lookup_pc = lpc[PC_W-1:0];
        upd_valid = uv[0]; upd_pc = upc[PC_W-1:0]; upd_hist = uhist[HIST_W-1:0]; upd_taken = utaken[0];
        #1;
        exp_ur = (mq.size() < 4);
        exp_lr = !mbub && exp_ur;
        checks++;
        if (lookup_ready !== exp_lr || upd_ready !== exp_ur) begin
            errors++;
            $display("FAIL ready: lookup_ready=%b upd_ready=%b expected %b %b", lookup_ready, upd_ready, exp_lr, exp_ur);
        end
        fire  = lv[0] && exp_lr;
        issue = !fire && !mbub && mq.size() > 0;
        checks++;
        if (lht_en !== (fire || issue)) begin
            errors++;
            $display("FAIL lht_en: got %b expected %b", lht_en, fire || issue);
        end
        if (fire) begin
            checks++;
            if (lht_we !== 1'b0 || lht_addr !== PC_W'(lpc)) begin
                errors++;
                $display("FAIL lookup_lht: we=%b addr=%h expected 0 %h", lht_we, lht_addr, lpc);
            end
        end
        if (issue) begin
            h = mq[0];
            checks++;
            if (lht_we !== 1'b1 || lht_addr !== PC_W'(h.pc) ||
                lht_wdata !== HIST_W'(((h.hist * 2) % DEPTH) + h.taken)) begin
                errors++;
                $display("FAIL update_lht: we=%b addr=%h wdata=%h expected 1 %h %h", lht_we, lht_addr,
                         lht_wdata, h.pc, ((h.hist * 2) % DEPTH) + h.taken);
            end
        end
        checks++;
        if (pred_valid !== po_v || (po_v && (pred_taken !== po_t[0] || pred_hist !== HIST_W'(po_h)))) begin
            errors++;
            $display("FAIL pred: valid=%b taken=%b hist=%h expected %b %0d %h", pred_valid, pred_taken,
                     pred_hist, po_v, po_t, po_h);
        end
        nv = fire; nt = 0; nh = 0;
        if (fire) begin
            nh = mlht[lpc];
            nt = (mlpt[nh] >= 4) ? 1 : 0;
        end
        if (issue) begin
            h = mq.pop_front();
            mlht[h.pc] = ((h.hist * 2) % DEPTH) + h.taken;
            c = mlpt[h.hist];
            if (h.taken != 0) c = (c < 7) ? c + 1 : 7;
            else              c = (c > 0) ? c - 1 : 0;
            mlpt[h.hist] = c;
        end
        acc_upd = uv[0] && exp_ur;
        if (acc_upd) begin
            e.pc = upc; e.hist = uhist; e.taken = utaken;
            mq.push_back(e);
        end
        mbub = issue;
        po_v = sr1_v; po_t = sr1_t; po_h = sr1_h;
        sr1_v = sr0_v; sr1_t = sr0_t; sr1_h = sr0_h;
        sr0_v = nv; sr0_t = nt; sr0_h = nh;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        lv = 0; uv = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Entered at a falling edge with the sweep at address 0.
    task automatic run_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (init_busy !== 1'b1 || lht_en !== 1'b1 || lht_we !== 1'b1 || lht_addr !== PC_W'(i) ||
                lht_wdata !== '0 || lpt_en !== 1'b1 || lpt_we !== 1'b1 || lpt_addr !== HIST_W'(i) ||
                lpt_wdata !== '0 || lookup_ready !== 1'b0 || upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL sweep[%0d]: busy=%b lht=%b%b@%h:%h lpt=%b%b@%h:%h rdy=%b%b", i, init_busy,
                         lht_en, lht_we, lht_addr, lht_wdata, lpt_en, lpt_we, lpt_addr, lpt_wdata,
                         lookup_ready, upd_ready);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (init_busy !== 1'b1 || pred_valid !== 1'b0 || lookup_ready !== 1'b0 || upd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b pv=%b rdy=%b%b expected 1 0 00", init_busy, pred_valid,
                     lookup_ready, upd_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        run_sweep(DEPTH);
        model_reset();
        #1;
        checks++;
        if (init_busy !== 1'b0) begin
            errors++;
            $display("FAIL init_done: init_busy=%b expected 0", init_busy);
        end
        @(negedge clock);
        idle(2);
    endtask

    task automatic test_lookup();
        lv = 1; lpc = 5; uv = 0;
        tick();
        lv = 0;
        #1;
        checks++;
        if (lpt_en !== 1'b1 || lpt_we !== 1'b0 || lpt_addr !== '0) begin
            errors++;
            $display("FAIL lookup_lpt: en=%b we=%b addr=%h expected 1 0 000", lpt_en, lpt_we, lpt_addr);
        end
        tick();
        tick();
        #1;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_hist !== '0) begin
            errors++;
            $display("FAIL lookup_pred: valid=%b taken=%b hist=%h expected 1 0 000", pred_valid, pred_taken, pred_hist);
        end
        idle(2);
    endtask

    task automatic test_train();
        lv = 0; uv = 1; upc = 5; uhist = 0; utaken = 1;
        for (int i = 0; i < 4; i++) tick();
        idle(12);
        #1;
        checks++;
        if (lpt_mem[0] !== 3'd4 || lht_mem[5] !== 10'h001) begin
            errors++;
            $display("FAIL train_tables: lpt[0]=%0d lht[5]=%h expected 4 001", lpt_mem[0], lht_mem[5]);
        end
        lv = 1; lpc = 3;
        tick();
        lv = 0;
        tick();
        tick();
        #1;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_hist !== '0) begin
            errors++;
            $display("FAIL train_pc3: valid=%b taken=%b hist=%h expected 1 1 000", pred_valid, pred_taken, pred_hist);
        end
        lv = 1; lpc = 5;
        tick();
        lv = 0;
        #1;
        checks++;
        if (lpt_addr !== 10'h001) begin
            errors++;
            $display("FAIL train_pc5_addr: lpt_addr=%h expected 001", lpt_addr);
        end
        tick();
        tick();
        #1;
        checks++;
        if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_hist !== 10'h001) begin
            errors++;
            $display("FAIL train_pc5: valid=%b taken=%b hist=%h expected 1 0 001", pred_valid, pred_taken, pred_hist);
        end
        idle(2);
    endtask

    task automatic test_saturate();
        int n = 0;
        lv = 0; uv = 1; upc = 7; uhist = 10'h3FF; utaken = 1;
        for (int i = 0; i < 100 && n < 9; i++) begin
            tick();
            if (acc_upd) n++;
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL sat_push: accepted %0d expected 9", n);
        end
        idle(12);
        #1;
        checks++;
        if (lpt_mem[10'h3FF] !== 3'd7) begin
            errors++;
            $display("FAIL sat_high: lpt[3FF]=%0d expected 7", lpt_mem[10'h3FF]);
        end
        uv = 1; utaken = 0;
        tick();
        idle(6);
        #1;
        checks++;
        if (lpt_mem[10'h3FF] !== 3'd6) begin
            errors++;
            $display("FAIL sat_dec: lpt[3FF]=%0d expected 6", lpt_mem[10'h3FF]);
        end
    endtask

    task automatic test_back_to_back();
        lv = 1; lpc = 5; uv = 1;
        for (int i = 0; i < 4; i++) begin
            upc = 10 + i; uhist = $urandom_range(0, DEPTH - 1); utaken = $urandom_range(0, 1);
            tick();
        end
        uv = 0;
        #1;
        checks++;
        if (upd_ready !== 1'b0 || lookup_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: upd_ready=%b lookup_ready=%b expected 0 0", upd_ready, lookup_ready);
        end
        tick();
        #1;
        checks++;
        if (lht_en !== 1'b0 || lookup_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_bubble: lht_en=%b lookup_ready=%b expected 0 0", lht_en, lookup_ready);
        end
        for (int i = 0; i < 3; i++) tick();
        idle(14);
        #1;
        checks++;
        if (upd_ready !== 1'b1 || lookup_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain: upd_ready=%b lookup_ready=%b expected 1 1", upd_ready, lookup_ready);
        end
    endtask

    task automatic test_random();
        int hset [4];
        for (int i = 0; i < 4; i++) hset[i] = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < 500; i++) begin
            lv = ($urandom_range(0, 99) < 50) ? 1 : 0;
            lpc = $urandom_range(0, 7);
            uv = ($urandom_range(0, 99) < 40) ? 1 : 0;
            upc = $urandom_range(0, 7);
            uhist = ($urandom_range(0, 1) != 0) ? hset[$urandom_range(0, 3)] : int'($urandom_range(0, DEPTH - 1));
            utaken = $urandom_range(0, 1);
            tick();
        end
        idle(14);
        for (int a = 0; a < DEPTH; a++) begin
            checks++;
            if (lht_mem[a] !== HIST_W'(mlht[a]) || lpt_mem[a] !== CNT_W'(mlpt[a])) begin
                errors++;
                $display("FAIL tables[%0d]: lht=%h lpt=%0d expected %h %0d", a, lht_mem[a], lpt_mem[a], mlht[a], mlpt[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        run_sweep(500);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (init_busy !== 1'b1 || lht_addr !== '0 || lpt_addr !== '0) begin
            errors++;
            $display("FAIL mid_sweep_reset: busy=%b lht_addr=%h lpt_addr=%h expected 1 000 000", init_busy, lht_addr, lpt_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        run_sweep(DEPTH);
        model_reset();
        lv = 1; lpc = 2; uv = 1; upc = 4; uhist = 9; utaken = 1;
        tick();
        tick();
        uv = 0;
        tick();
        lv = 0;
        tick();
        #2 reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (pred_valid !== 1'b0 || init_busy !== 1'b1 || upd_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_reset[%0d]: pred_valid=%b busy=%b upd_ready=%b expected 0 1 0", i, pred_valid, init_busy, upd_ready);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        run_sweep(DEPTH);
        model_reset();
        idle(6);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            lht_mem[i] = HIST_W'($urandom);
            lpt_mem[i] = CNT_W'($urandom);
        end
        lv = 0; lpc = 0; uv = 0; upc = 0; uhist = 0; utaken = 0;
        model_reset();
        test_reset();
        test_lookup();
        test_train();
        test_saturate();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
